// File: rtl/venda_pkg.sv
// Shared definitions for the vending sequencing controller: coin codes, FSM states and
// the coin-to-quarters weight function.
package venda_pkg;

  localparam logic [1:0] MoedaNenhuma = 2'b00;
  localparam logic [1:0] Moeda25      = 2'b01;
  localparam logic [1:0] Moeda50      = 2'b10;
  localparam logic [1:0] Moeda100     = 2'b11;

  localparam logic [3:0] CreditoMax = 4'd8;

  typedef enum logic [1:0] {
    StOcioso,
    StAcumulando,
    StLiberando,
    StTroco
  } estado_e;

  function automatic logic [2:0] quartos(input logic [1:0] valor_moeda);
    logic [2:0] peso;
    case (valor_moeda)
      Moeda25:  peso = 3'd1;
      Moeda50:  peso = 3'd2;
      Moeda100: peso = 3'd4;
      default:  peso = 3'd0;
    endcase
    return peso;
  endfunction

endpackage

// File: rtl/temporizador_inatividade.sv
// Inactivity counter: runs while enabled, restarts on limpar, flags the cycle whose
// closing edge completes TEMPO_LIMITE idle cycles.
module temporizador_inatividade #(
  parameter int unsigned TEMPO_LIMITE = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic limpar,
  input  logic habilitar,
  output logic expirou
);

  localparam int unsigned Largura = $clog2(TEMPO_LIMITE + 1);
  localparam logic [Largura-1:0] Limite = Largura'(TEMPO_LIMITE);
  localparam logic [Largura-1:0] Ultimo = Largura'(TEMPO_LIMITE - 1);

  logic [Largura-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (limpar || !habilitar) begin
      cnt_d = '0;
    end else if (cnt_q != Limite) begin
      cnt_d = cnt_q + Largura'(1);
    end
  end

  // Asserted one cycle early so the registered outputs change exactly on the limit edge.
  assign expirou = habilitar && !limpar && (cnt_q == Ultimo);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/controle_venda.sv
// Vending sequencing controller: tracks coin credit, checks requests against prices,
// handles dispense and change handshakes, refunds after inactivity.
module controle_venda
  import venda_pkg::*;
#(
  parameter int unsigned PRECO0       = 3,
  parameter int unsigned PRECO1       = 4,
  parameter int unsigned PRECO2       = 6,
  parameter int unsigned PRECO3       = 8,
  parameter int unsigned TEMPO_LIMITE = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valorMoeda,
  input  logic       pedido,
  input  logic [1:0] selecao,
  input  logic       entregue,
  input  logic       trocoAck,
  output logic [3:0] valorAcumulado,
  output logic       liberar,
  output logic [1:0] produto,
  output logic       trocoValido,
  output logic [3:0] trocoQuartos,
  output logic       rejeitaMoeda,
  output logic       faltaCredito
);

  estado_e    estado_q, estado_d;
  logic [3:0] credito_q, credito_d;
  logic [1:0] produto_q, produto_d;
  logic       liberar_q, troco_valido_q, rejeita_q, rejeita_d, falta_q, falta_d;
  logic [3:0] troco_quartos_q;

  logic       moeda;
  logic [2:0] peso;
  logic [4:0] soma;
  logic [3:0] preco;
  logic       habilitar, limpar, expirou;

  assign moeda = (valorMoeda != MoedaNenhuma);
  assign peso  = quartos(valorMoeda);
  assign soma  = {1'b0, credito_q} + {2'b00, peso};

  always_comb begin
    case (selecao)
      2'd0:    preco = 4'(PRECO0);
      2'd1:    preco = 4'(PRECO1);
      2'd2:    preco = 4'(PRECO2);
      default: preco = 4'(PRECO3);
    endcase
  end

  // Any coin or request while accumulating restarts the idle window, even if refused.
  assign habilitar = (estado_q == StAcumulando);
  assign limpar    = habilitar && (moeda || pedido);

  temporizador_inatividade #(
    .TEMPO_LIMITE(TEMPO_LIMITE)
  ) u_temporizador (
    .clk      (clk),
    .rst_n    (rst_n),
    .limpar   (limpar),
    .habilitar(habilitar),
    .expirou  (expirou)
  );

  always_comb begin
    estado_d  = estado_q;
    credito_d = credito_q;
    produto_d = produto_q;
    rejeita_d = 1'b0;
    falta_d   = 1'b0;
    case (estado_q)
      StOcioso: begin
        if (moeda) begin
          credito_d = {1'b0, peso};
          estado_d  = StAcumulando;
        end
        if (pedido) begin
          falta_d = 1'b1;
        end
      end
      StAcumulando: begin
        if (pedido) begin
          // Request is judged on pre-coin credit; a coin arriving alongside is refused.
          if (credito_q >= preco) begin
            credito_d = credito_q - preco;
            produto_d = selecao;
            estado_d  = StLiberando;
          end else begin
            falta_d = 1'b1;
          end
          rejeita_d = moeda;
        end else if (moeda) begin
          if (soma <= {1'b0, CreditoMax}) begin
            credito_d = soma[3:0];
          end else begin
            rejeita_d = 1'b1;
          end
        end else if (expirou) begin
          estado_d = StTroco;
        end
      end
      StLiberando: begin
        rejeita_d = moeda;
        if (entregue) begin
          estado_d = (credito_q != 4'd0) ? StTroco : StOcioso;
        end
      end
      StTroco: begin
        rejeita_d = moeda;
        if (trocoAck) begin
          credito_d = '0;
          estado_d  = StOcioso;
        end
      end
      default: estado_d = StOcioso;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado_q        <= StOcioso;
      credito_q       <= '0;
      produto_q       <= '0;
      liberar_q       <= 1'b0;
      troco_valido_q  <= 1'b0;
      troco_quartos_q <= '0;
      rejeita_q       <= 1'b0;
      falta_q         <= 1'b0;
    end else begin
      estado_q        <= estado_d;
      credito_q       <= credito_d;
      produto_q       <= produto_d;
      liberar_q       <= (estado_d == StLiberando);
      troco_valido_q  <= (estado_d == StTroco);
      troco_quartos_q <= (estado_d == StTroco) ? credito_d : 4'd0;
      rejeita_q       <= rejeita_d;
      falta_q         <= falta_d;
    end
  end

  assign valorAcumulado = credito_q;
  assign liberar        = liberar_q;
  assign produto        = produto_q;
  assign trocoValido    = troco_valido_q;
  assign trocoQuartos   = troco_quartos_q;
  assign rejeitaMoeda   = rejeita_q;
  assign faltaCredito   = falta_q;

endmodule

// File: tb/tb_controle_venda.sv
// Self-checking bench for controle_venda: directed scenarios plus randomized traffic
// checked against a credit/mode reference model.
module tb_controle_venda;

  localparam int unsigned T = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] valorMoeda = 2'b00;
  logic       pedido = 1'b0;
  logic [1:0] selecao = 2'b00;
  logic       entregue = 1'b0;
  logic       trocoAck = 1'b0;
  logic [3:0] valorAcumulado;
  logic       liberar;
  logic [1:0] produto;
  logic       trocoValido;
  logic [3:0] trocoQuartos;
  logic       rejeitaMoeda;
  logic       faltaCredito;

  int n_run = 0;
  int n_fail = 0;

  // Reference model: credit in quarters plus two handshake flags.
  int m_credito = 0;
  bit m_disp = 0;
  bit m_ref = 0;
  int m_prod = 0;
  int m_ociosos = 0;
  bit m_rej = 0;
  bit m_falta = 0;
  int precos[4] = '{3, 4, 6, 8};

  controle_venda #(
    .PRECO0      (3),
    .PRECO1      (4),
    .PRECO2      (6),
    .PRECO3      (8),
    .TEMPO_LIMITE(T)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .valorMoeda    (valorMoeda),
    .pedido        (pedido),
    .selecao       (selecao),
    .entregue      (entregue),
    .trocoAck      (trocoAck),
    .valorAcumulado(valorAcumulado),
    .liberar       (liberar),
    .produto       (produto),
    .trocoValido   (trocoValido),
    .trocoQuartos  (trocoQuartos),
    .rejeitaMoeda  (rejeitaMoeda),
    .faltaCredito  (faltaCredito)
  );

  always #5 clk = ~clk;

  task automatic modelo(input bit rst, input int c, input bit ped, input int sel,
                        input bit ent, input bit ack);
    int w;
    w = (c == 1) ? 1 : (c == 2) ? 2 : (c == 3) ? 4 : 0;
    m_rej = 0;
    m_falta = 0;
    if (rst) begin
      m_credito = 0; m_disp = 0; m_ref = 0; m_prod = 0; m_ociosos = 0;
    end else if (m_disp) begin
      m_rej = (w != 0);
      if (ent) begin
        m_disp = 0;
        if (m_credito > 0) m_ref = 1;
      end
    end else if (m_ref) begin
      m_rej = (w != 0);
      if (ack) begin
        m_ref = 0;
        m_credito = 0;
      end
    end else if (m_credito == 0) begin
      if (w != 0) begin
        m_credito = w;
        m_ociosos = 0;
      end
      if (ped) m_falta = 1;
    end else begin
      if (ped) begin
        m_ociosos = 0;
        if (m_credito >= precos[sel]) begin
          m_credito -= precos[sel];
          m_prod = sel;
          m_disp = 1;
        end else begin
          m_falta = 1;
        end
        m_rej = (w != 0);
      end else if (w != 0) begin
        m_ociosos = 0;
        if (m_credito + w <= 8) m_credito += w;
        else m_rej = 1;
      end else begin
        m_ociosos++;
        if (m_ociosos == T) m_ref = 1;
      end
    end
  endtask

  // Drive one cycle of inputs on the falling edge, sample just after the rising edge.
  task automatic passo(input bit rst, input int c, input bit ped, input int sel,
                       input bit ent, input bit ack);
    @(negedge clk);
    rst_n = ~rst;
    valorMoeda = 2'(c);
    pedido = ped;
    selecao = 2'(sel);
    entregue = ent;
    trocoAck = ack;
    modelo(rst, c, ped, sel, ent, ack);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    passo(1, 0, 0, 0, 0, 0);
    passo(1, 0, 0, 0, 0, 0);
    n_run++;
    if ({valorAcumulado, liberar, trocoValido, trocoQuartos, rejeitaMoeda, faltaCredito}
        !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got cred=%0d lib=%b tv=%b tq=%0d rej=%b falta=%b want all 0",
               valorAcumulado, liberar, trocoValido, trocoQuartos, rejeitaMoeda, faltaCredito);
    end
  endtask

  task automatic test_compra_exata();
    passo(1, 0, 0, 0, 0, 0);
    passo(0, 2, 0, 0, 0, 0);
    n_run++;
    if (valorAcumulado !== 4'd2) begin
      n_fail++; $display("FAIL exata_c1: got %0d want 2", valorAcumulado);
    end
    passo(0, 2, 0, 0, 0, 0);
    n_run++;
    if (valorAcumulado !== 4'd4) begin
      n_fail++; $display("FAIL exata_c2: got %0d want 4", valorAcumulado);
    end
    passo(0, 0, 1, 1, 0, 0);
    n_run++;
    if (liberar !== 1'b1 || produto !== 2'd1 || valorAcumulado !== 4'd0) begin
      n_fail++;
      $display("FAIL exata_pedido: got lib=%b prod=%0d cred=%0d want lib=1 prod=1 cred=0",
               liberar, produto, valorAcumulado);
    end
    passo(0, 0, 0, 0, 1, 0);
    n_run++;
    if (liberar !== 1'b0 || trocoValido !== 1'b0) begin
      n_fail++;
      $display("FAIL exata_entregue: got lib=%b tv=%b want lib=0 tv=0", liberar, trocoValido);
    end
  endtask

  task automatic test_troco();
    passo(1, 0, 0, 0, 0, 0);
    passo(0, 3, 0, 0, 0, 0);
    passo(0, 1, 0, 0, 0, 0);
    n_run++;
    if (valorAcumulado !== 4'd5) begin
      n_fail++; $display("FAIL troco_cred: got %0d want 5", valorAcumulado);
    end
    passo(0, 0, 1, 0, 0, 0);
    n_run++;
    if (liberar !== 1'b1 || produto !== 2'd0 || valorAcumulado !== 4'd2) begin
      n_fail++;
      $display("FAIL troco_pedido: got lib=%b prod=%0d cred=%0d want lib=1 prod=0 cred=2",
               liberar, produto, valorAcumulado);
    end
    passo(0, 0, 0, 0, 1, 0);
    n_run++;
    if (liberar !== 1'b0 || trocoValido !== 1'b1 || trocoQuartos !== 4'd2) begin
      n_fail++;
      $display("FAIL troco_entregue: got lib=%b tv=%b tq=%0d want lib=0 tv=1 tq=2",
               liberar, trocoValido, trocoQuartos);
    end
    passo(0, 0, 0, 0, 0, 1);
    n_run++;
    if (trocoValido !== 1'b0 || valorAcumulado !== 4'd0) begin
      n_fail++;
      $display("FAIL troco_ack: got tv=%b cred=%0d want tv=0 cred=0", trocoValido,
               valorAcumulado);
    end
  endtask

  task automatic test_saturacao();
    passo(1, 0, 0, 0, 0, 0);
    passo(0, 3, 0, 0, 0, 0);
    passo(0, 3, 0, 0, 0, 0);
    n_run++;
    if (valorAcumulado !== 4'd8 || rejeitaMoeda !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_cheio: got cred=%0d rej=%b want cred=8 rej=0", valorAcumulado,
               rejeitaMoeda);
    end
    passo(0, 1, 0, 0, 0, 0);
    n_run++;
    if (valorAcumulado !== 4'd8 || rejeitaMoeda !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_rejeita: got cred=%0d rej=%b want cred=8 rej=1", valorAcumulado,
               rejeitaMoeda);
    end
    passo(0, 0, 0, 0, 0, 0);
    n_run++;
    if (rejeitaMoeda !== 1'b0) begin
      n_fail++; $display("FAIL sat_pulso: got rej=%b want 0", rejeitaMoeda);
    end
    passo(0, 0, 1, 3, 0, 0);
    n_run++;
    if (liberar !== 1'b1 || produto !== 2'd3 || valorAcumulado !== 4'd0) begin
      n_fail++;
      $display("FAIL sat_pedido: got lib=%b prod=%0d cred=%0d want lib=1 prod=3 cred=0",
               liberar, produto, valorAcumulado);
    end
    passo(0, 2, 0, 0, 0, 0);
    n_run++;
    if (rejeitaMoeda !== 1'b1 || valorAcumulado !== 4'd0 || liberar !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_moeda_liberando: got rej=%b cred=%0d lib=%b want rej=1 cred=0 lib=1",
               rejeitaMoeda, valorAcumulado, liberar);
    end
    passo(0, 0, 0, 0, 1, 0);
    n_run++;
    if (trocoValido !== 1'b0 || liberar !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_entregue: got tv=%b lib=%b want 0 0", trocoValido, liberar);
    end
  endtask

  task automatic test_timeout();
    passo(1, 0, 0, 0, 0, 0);
    passo(0, 0, 1, 0, 0, 0);
    n_run++;
    if (faltaCredito !== 1'b1) begin
      n_fail++; $display("FAIL tmo_pedido_ocioso: got falta=%b want 1", faltaCredito);
    end
    passo(0, 1, 0, 0, 0, 0);
    passo(0, 0, 1, 2, 0, 0);
    n_run++;
    if (faltaCredito !== 1'b1 || valorAcumulado !== 4'd1 || liberar !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_falta: got falta=%b cred=%0d lib=%b want falta=1 cred=1 lib=0",
               faltaCredito, valorAcumulado, liberar);
    end
    for (int i = 0; i < int'(T) - 1; i++) passo(0, 0, 0, 0, 0, 0);
    n_run++;
    if (trocoValido !== 1'b0) begin
      n_fail++; $display("FAIL tmo_cedo: got tv=%b want 0 at cycle %0d", trocoValido, T - 1);
    end
    passo(0, 0, 0, 0, 0, 0);
    n_run++;
    if (trocoValido !== 1'b1 || trocoQuartos !== 4'd1) begin
      n_fail++;
      $display("FAIL tmo_expira: got tv=%b tq=%0d want tv=1 tq=1", trocoValido, trocoQuartos);
    end
    passo(0, 0, 0, 0, 0, 1);
    n_run++;
    if (trocoValido !== 1'b0 || valorAcumulado !== 4'd0) begin
      n_fail++;
      $display("FAIL tmo_ack: got tv=%b cred=%0d want 0 0", trocoValido, valorAcumulado);
    end
  endtask

  task automatic test_simultaneo();
    passo(1, 0, 0, 0, 0, 0);
    passo(0, 2, 0, 0, 0, 0);
    passo(0, 2, 1, 0, 0, 0);
    n_run++;
    if (faltaCredito !== 1'b1 || rejeitaMoeda !== 1'b1 || valorAcumulado !== 4'd2 ||
        liberar !== 1'b0) begin
      n_fail++;
      $display("FAIL simult: got falta=%b rej=%b cred=%0d lib=%b want falta=1 rej=1 cred=2 lib=0",
               faltaCredito, rejeitaMoeda, valorAcumulado, liberar);
    end
  endtask

  task automatic test_reset_handshake();
    passo(1, 0, 0, 0, 0, 0);
    passo(0, 3, 0, 0, 0, 0);
    passo(0, 0, 1, 1, 0, 0);
    n_run++;
    if (liberar !== 1'b1) begin
      n_fail++; $display("FAIL rsths_liberar: got lib=%b want 1", liberar);
    end
    passo(1, 0, 0, 0, 0, 0);
    n_run++;
    if (liberar !== 1'b0 || valorAcumulado !== 4'd0 || trocoValido !== 1'b0) begin
      n_fail++;
      $display("FAIL rsths_reset: got lib=%b cred=%0d tv=%b want 0 0 0", liberar,
               valorAcumulado, trocoValido);
    end
    passo(0, 1, 0, 0, 0, 0);
    n_run++;
    if (valorAcumulado !== 4'd1 || rejeitaMoeda !== 1'b0) begin
      n_fail++;
      $display("FAIL rsths_ocioso: got cred=%0d rej=%b want cred=1 rej=0", valorAcumulado,
               rejeitaMoeda);
    end
  endtask

  task automatic test_aleatorio(input int ciclos);
    int c, sel, exp_tq;
    bit ped, ent, ack, rst, ok;
    passo(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < ciclos; i++) begin
      c   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
      ped = ($urandom_range(0, 3) == 0);
      sel = int'($urandom_range(0, 3));
      ent = ($urandom_range(0, 2) == 0);
      ack = ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 199) == 0);
      passo(rst, c, ped, sel, ent, ack);
      exp_tq = m_ref ? m_credito : 0;
      ok = (liberar === m_disp) && (trocoValido === m_ref) &&
           (trocoQuartos === 4'(exp_tq)) && (rejeitaMoeda === m_rej) &&
           (faltaCredito === m_falta) && (valorAcumulado === 4'(m_credito)) &&
           (!m_disp || produto === 2'(m_prod));
      n_run++;
      if (!ok) begin
        n_fail++;
        $display("FAIL aleatorio[%0d]: got cred=%0d lib=%b prod=%0d tv=%b tq=%0d rej=%b falta=%b want cred=%0d lib=%b prod=%0d tv=%b tq=%0d rej=%b falta=%b",
                 i, valorAcumulado, liberar, produto, trocoValido, trocoQuartos, rejeitaMoeda,
                 faltaCredito, m_credito, m_disp, m_prod, m_ref, exp_tq, m_rej, m_falta);
      end
    end
  endtask

  initial begin
    test_reset();
    test_compra_exata();
    test_troco();
    test_saturacao();
    test_timeout();
    test_simultaneo();
    test_reset_handshake();
    test_aleatorio(3000);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
